// File: rtl/gauss_filter_pkg.sv
// Shared BTLE TX constants for the Gaussian pulse shaper: default widths/rates,
// the 2-bit symbol encoding and small sizing helpers.
package gauss_filter_pkg;

    localparam int BTLE_GAUSS_FILTER_BIT_WIDTH = 16;
    localparam int BTLE_VCO_BIT_WIDTH          = BTLE_GAUSS_FILTER_BIT_WIDTH;
    localparam int BTLE_SAMPLE_PER_SYMBOL      = 8;
    localparam int BTLE_NUM_TAP                = 17;
    localparam int BTLE_TAP_ADDR_BIT_WIDTH     = 5;
    localparam int BTLE_OUT_INTERVAL           = 2;

    // Symbol history encoding: two's-complement style so bit 1 acts as a sign.
    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_P1   = 2'b01;
    localparam logic [1:0] SYM_M1   = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    function automatic int num_hist(input int num_tap, input int sps);
        return (num_tap + sps - 1) / sps;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] encode_symbol(input logic bit_val, input logic flush);
        if (flush) begin
            return SYM_ZERO;
        end
        return bit_val ? SYM_P1 : SYM_M1;
    endfunction

endpackage

// File: rtl/gauss_filter_phase_sum.sv
// Combinational polyphase sum for one output phase: adds, subtracts or skips each
// tap according to the stored symbol, then saturates to the output width.
module gauss_filter_phase_sum
    import gauss_filter_pkg::*;
#(
    parameter int W        = BTLE_GAUSS_FILTER_BIT_WIDTH,
    parameter int NUM_TAP  = BTLE_NUM_TAP,
    parameter int SPS      = BTLE_SAMPLE_PER_SYMBOL,
    parameter int NUM_HIST = num_hist(NUM_TAP, SPS),
    parameter int PHASE_W  = cnt_width(SPS)
) (
    input  logic [NUM_TAP-1:0][W-1:0]  i_taps,
    input  logic [NUM_HIST-1:0][1:0]   i_hist,
    input  logic [PHASE_W-1:0]         i_phase,
    output logic signed [W-1:0]        o_sample
);

    localparam int ACC_W = W + 2;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{3{1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{3{1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_acc;

    // Tap k belongs to phase k % SPS and multiplies history slot k / SPS.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves w_acc unassigned
        // (otherwise a latch is inferred).
        w_acc = '0;
        for (int k = 0; k < NUM_TAP; k++) begin
            if (PHASE_W'(k % SPS) == i_phase) begin
                case (i_hist[k / SPS])
                    SYM_P1:  w_acc = w_acc + ACC_W'($signed(i_taps[k]));
                    SYM_M1:  w_acc = w_acc - ACC_W'($signed(i_taps[k]));
                    default: w_acc = w_acc;
                endcase
            end
        end
    end

    always_comb begin
        if (w_acc > SAT_MAX) begin
            o_sample = {1'b0, {(W-1){1'b1}}};
        end else if (w_acc < SAT_MIN) begin
            o_sample = {1'b1, {(W-1){1'b0}}};
        end else begin
            o_sample = w_acc[W-1:0];
        end
    end

endmodule

// File: rtl/gauss_filter.sv
// GFSK Gaussian pulse shaper: takes one symbol per ready/valid handshake and emits
// SAMPLE_PER_SYMBOL filtered samples, OUT_INTERVAL clocks apart, to the vco.
module gauss_filter
    import gauss_filter_pkg::*;
#(
    parameter int GAUSS_FILTER_BIT_WIDTH = BTLE_GAUSS_FILTER_BIT_WIDTH,
    parameter int NUM_TAP                = BTLE_NUM_TAP,
    parameter int TAP_ADDR_BIT_WIDTH     = BTLE_TAP_ADDR_BIT_WIDTH,
    parameter int SAMPLE_PER_SYMBOL      = BTLE_SAMPLE_PER_SYMBOL,
    parameter int OUT_INTERVAL           = BTLE_OUT_INTERVAL
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     tap_write_enable,
    input  logic [TAP_ADDR_BIT_WIDTH-1:0]            tap_write_address,
    input  logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] tap_write_data,
    input  logic                                     bit_in,
    input  logic                                     bit_in_flush,
    input  logic                                     bit_in_valid,
    output logic                                     bit_in_ready,
    output logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] voltage_signal,
    output logic                                     voltage_signal_valid
);

    localparam int W        = GAUSS_FILTER_BIT_WIDTH;
    localparam int SPS      = SAMPLE_PER_SYMBOL;
    localparam int NUM_HIST = num_hist(NUM_TAP, SPS);
    localparam int PHASE_W  = cnt_width(SPS);
    localparam int CNT_W    = cnt_width(OUT_INTERVAL);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SPS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(OUT_INTERVAL - 1);

    state_t                      r_state;
    logic [NUM_TAP-1:0][W-1:0]   r_taps;
    logic [NUM_HIST-1:0][1:0]    r_hist;
    logic [PHASE_W-1:0]          r_phase;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [W-1:0]         r_voltage;
    logic                        r_valid;

    logic                        w_accept;
    logic [1:0]                  w_sym;
    logic signed [W-1:0]         w_sample;

    assign bit_in_ready = (r_state == ST_IDLE) ||
                          ((r_state == ST_EMIT) && (r_phase == PHASE_LAST) && (r_cnt == CNT_LAST));
    assign w_accept     = bit_in_valid && bit_in_ready;
    assign w_sym        = encode_symbol(bit_in, bit_in_flush);

    assign voltage_signal       = r_voltage;
    assign voltage_signal_valid = r_valid;

    // Out-of-range addresses match no index and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tap bank is deliberately cleared by reset; the loader must
            // rewrite it afterwards.
            r_taps <= '0;
        end else if (tap_write_enable) begin
            for (int k = 0; k < NUM_TAP; k++) begin
                if (int'(tap_write_address) == k) begin
                    r_taps[k] <= tap_write_data;
                end
            end
        end
    end

    gauss_filter_phase_sum #(
        .W        (W),
        .NUM_TAP  (NUM_TAP),
        .SPS      (SPS),
        .NUM_HIST (NUM_HIST),
        .PHASE_W  (PHASE_W)
    ) u_phase_sum (
        .i_taps   (r_taps),
        .i_hist   (r_hist),
        .i_phase  (r_phase),
        .o_sample (w_sample)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_hist    <= '0;
            r_phase   <= '0;
            r_cnt     <= '0;
            r_voltage <= '0;
            r_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so the sample registered this edge uses
            // the history/taps from before any same-edge accept or tap write.
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hist  <= {r_hist[NUM_HIST-2:0], w_sym};
                        r_phase <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (r_cnt == '0) begin
                        r_voltage <= w_sample;
                        r_valid   <= 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_phase == PHASE_LAST) begin
                            // Final slot: chain straight into the next symbol if one is offered.
                            if (w_accept) begin
                                r_hist  <= {r_hist[NUM_HIST-2:0], w_sym};
                                r_phase <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_filter.sv
// Self-checking bench for gauss_filter: a symbol-level reference model pushes expected
// samples (value and emission edge) into a scoreboard that a negedge monitor drains.
module tb_gauss_filter;

    localparam int W   = 16;
    localparam int NT  = 17;
    localparam int AW  = 5;
    localparam int SPS = 8;
    localparam int OI  = 2;
    localparam int NH  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 tap_write_enable = 1'b0;
    logic [AW-1:0]        tap_write_address = '0;
    logic signed [W-1:0]  tap_write_data = '0;
    logic                 bit_in = 1'b0;
    logic                 bit_in_flush = 1'b0;
    logic                 bit_in_valid = 1'b0;
    logic                 bit_in_ready;
    logic signed [W-1:0]  voltage_signal;
    logic                 voltage_signal_valid;

    gauss_filter #(
        .GAUSS_FILTER_BIT_WIDTH (W),
        .NUM_TAP                (NT),
        .TAP_ADDR_BIT_WIDTH     (AW),
        .SAMPLE_PER_SYMBOL      (SPS),
        .OUT_INTERVAL           (OI)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .tap_write_enable     (tap_write_enable),
        .tap_write_address    (tap_write_address),
        .tap_write_data       (tap_write_data),
        .bit_in               (bit_in),
        .bit_in_flush         (bit_in_flush),
        .bit_in_valid         (bit_in_valid),
        .bit_in_ready         (bit_in_ready),
        .voltage_signal       (voltage_signal),
        .voltage_signal_valid (voltage_signal_valid)
    );

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t q[$];
    int   taps_m[NT];
    int   hist_m[NH];
    int   cycle     = 0;
    int   last_edge = -1;
    int   n_checks  = 0;
    int   n_pass    = 0;
    bit   mon_en    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int expd);
        n_checks++;
        if (act == expd) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expd, cycle);
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) taps_m[k] = 0;
        for (int m = 0; m < NH; m++) hist_m[m] = 0;
        q.delete();
        last_edge = -1;
    endfunction

    // Symbol accepted at edge acc: y(p) = sum_m s[m]*tap[p+m*SPS], phase p appears at acc+1+p*OI.
    function automatic void model_accept(input bit b, input bit f, input int acc);
        exp_t e;
        int   y;
        for (int m = NH - 1; m > 0; m--) hist_m[m] = hist_m[m-1];
        hist_m[0] = f ? 0 : (b ? 1 : -1);
        for (int p = 0; p < SPS; p++) begin
            y = 0;
            for (int m = 0; m < NH; m++)
                if (p + m * SPS < NT) y += hist_m[m] * taps_m[p + m * SPS];
            e.val = sat(y);
            e.at  = acc + 1 + p * OI;
            q.push_back(e);
        end
        last_edge = acc + 1 + (SPS - 1) * OI;
    endfunction

    // Monitor: c is the index of the most recent rising edge.
    always @(negedge clk) begin
        int   c;
        exp_t e;
        if (mon_en && rst) begin
            c = cycle - 1;
            check("ready", int'(bit_in_ready), int'(c >= last_edge));
            if (voltage_signal_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", int'(voltage_signal_valid), 0);
                end else begin
                    e = q.pop_front();
                    check("sample_value", int'(voltage_signal), e.val);
                    check("sample_edge", c, e.at);
                end
            end else if (q.size() > 0 && q[0].at <= c) begin
                check("missed_sample", int'(voltage_signal_valid), 1);
                void'(q.pop_front());
            end
        end
    end

    // All driver tasks start and end just after a falling edge.
    task automatic write_tap(input int addr, input int data);
        tap_write_enable  = 1'b1;
        tap_write_address = AW'(addr);
        tap_write_data    = W'(data);
        @(posedge clk);
        #1;
        tap_write_enable = 1'b0;
        if (addr < NT) taps_m[addr] = int'($signed(W'(data)));
        @(negedge clk);
    endtask

    task automatic load_ramp_taps();
        for (int k = 0; k < NT; k++) write_tap(k, k + 1);
    endtask

    task automatic send(input bit b, input bit f);
        int t = 0;
        bit_in       = b;
        bit_in_flush = f;
        bit_in_valid = 1'b1;
        while (!bit_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bit_in_ready) begin
            check("accept_timeout", int'(bit_in_ready), 1);
            bit_in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(b, f, cycle - 1);
            @(negedge clk);
        end
    endtask

    task automatic idle_and_drain();
        int t = 0;
        bit_in_valid = 1'b0;
        while (q.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1);
    end

    initial begin
        int r;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", int'(voltage_signal_valid), 0);
        check("reset_voltage", int'(voltage_signal), 0);
        rst = 1'b1;
        #1;
        check("reset_ready", int'(bit_in_ready), 1);
        mon_en = 1'b1;
        @(negedge clk);

        // Ramp taps: 1..8, then all 8, then 9,-8,...
        load_ramp_taps();
        send(1, 0); idle_and_drain();
        send(0, 0); idle_and_drain();
        send(1, 0); idle_and_drain();

        // Back-to-back symbols with valid held high.
        for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), 0);
        idle_and_drain();

        // Tail drain with flush symbols.
        send(1, 0); send(0, 0);
        send(0, 1); send(0, 1); send(0, 1);
        idle_and_drain();

        // Out-of-range tap address must not disturb the bank.
        write_tap(20, 12345);
        write_tap(31, -999);
        send(1, 0); send(1, 0); send(0, 0);
        idle_and_drain();

        // Saturation both ways.
        for (int k = 0; k < NT; k++) write_tap(k, 32767);
        send(1, 0); send(1, 0); send(1, 0);
        idle_and_drain();
        send(0, 0); send(0, 0); send(0, 0);
        idle_and_drain();

        // Reset in the middle of emission, at phase 3.
        load_ramp_taps();
        send(1, 0);
        bit_in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check("midrst_valid", int'(voltage_signal_valid), 0);
        check("midrst_voltage", int'(voltage_signal), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(bit_in_ready), 1);
        send(1, 0); send(0, 0);
        idle_and_drain();

        // Single tap write from a clean history.
        do_reset();
        write_tap(0, 100);
        send(1, 0);
        idle_and_drain();

        // Randomized taps and symbols, with occasional idle gaps.
        for (int k = 0; k < NT; k++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) write_tap(k, int'($urandom_range(0, 65535)) - 32768);
            else write_tap(k, int'($urandom_range(0, 4000)) - 2000);
        end
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) begin
                bit_in_valid = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
        end
        idle_and_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
